// File: rtl/lenet_pkg.sv
// Shared LeNet controller definitions: default sizing constants and the
// layer-sequencer state type.
package lenet_pkg;

  localparam int unsigned SEQ_NUM_LAYERS = 4;
  localparam int unsigned SEQ_IDX_W      = 2;
  localparam int unsigned SEQ_TIMEOUT_W  = 20;
  localparam int unsigned SEQ_FRAME_W    = 16;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LAUNCH = 3'd1,
    SEQ_WAIT   = 3'd2,
    SEQ_NEXT   = 3'd3,
    SEQ_DONE   = 3'd4,
    SEQ_ERR    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/layer_sequencer_next_layer_find.sv
// Combinational search for the next enabled layer: lowest set mask bit when
// first_i is high, otherwise lowest set bit strictly above cur_i.
module next_layer_find
  import lenet_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = SEQ_NUM_LAYERS,
  parameter int unsigned IDX_W      = SEQ_IDX_W
) (
  input  logic [NUM_LAYERS-1:0] mask_i,
  input  logic [IDX_W-1:0]      cur_i,
  input  logic                  first_i,
  output logic [IDX_W-1:0]      next_o,
  output logic                  found_o
);

  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found_o && mask_i[i] && (first_i || (i > 32'(cur_i)))) begin
        next_o  = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Network-level controller: launches enabled layer engines in index order,
// toggles the ping-pong buffer per completed layer, and guards each layer with a watchdog.
module layer_sequencer
  import lenet_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = SEQ_NUM_LAYERS,
  parameter int unsigned IDX_W      = SEQ_IDX_W,
  parameter int unsigned TIMEOUT_W  = SEQ_TIMEOUT_W,
  parameter int unsigned FRAME_W    = SEQ_FRAME_W
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  net_start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_en_mask,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  mem_sel,
  output logic [IDX_W-1:0]      cur_layer,
  output logic                  busy,
  output logic                  net_done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_layer,
  output logic [FRAME_W-1:0]    frame_cnt
);

  seq_state_e            state_q;
  logic [NUM_LAYERS-1:0] mask_q;
  logic [TIMEOUT_W-1:0]  limit_q;
  logic [TIMEOUT_W-1:0]  timer_q;
  logic [IDX_W-1:0]      cur_q;
  logic                  mem_sel_q;
  logic                  error_q;
  logic [IDX_W-1:0]      err_layer_q;
  logic [FRAME_W-1:0]    frame_q;

  logic [NUM_LAYERS-1:0] find_mask;
  logic                  find_first;
  logic [IDX_W-1:0]      find_idx;
  logic                  find_found;

  // One finder serves both the start-of-frame search (live mask) and the
  // advance from NEXT (captured mask).
  always_comb begin
    find_first = (state_q == SEQ_IDLE);
    find_mask  = find_first ? layer_en_mask : mask_q;
  end

  next_layer_find #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_find (
    .mask_i  (find_mask),
    .cur_i   (cur_q),
    .first_i (find_first),
    .next_o  (find_idx),
    .found_o (find_found)
  );

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q     <= SEQ_IDLE;
      mask_q      <= '0;
      limit_q     <= '0;
      timer_q     <= '0;
      cur_q       <= '0;
      mem_sel_q   <= 1'b0;
      error_q     <= 1'b0;
      err_layer_q <= '0;
      frame_q     <= '0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (net_start) begin
            mask_q    <= layer_en_mask;
            limit_q   <= timeout_limit;
            mem_sel_q <= 1'b0;
            error_q   <= 1'b0;
            cur_q     <= find_idx;
            state_q   <= find_found ? SEQ_LAUNCH : SEQ_DONE;
          end
        end
        SEQ_LAUNCH: begin
          if (abort) begin
            state_q <= SEQ_IDLE;
          end else begin
            timer_q <= '0;
            state_q <= SEQ_WAIT;
          end
        end
        SEQ_WAIT: begin
          if (abort) begin
            state_q <= SEQ_IDLE;
          end else if (layer_done[cur_q]) begin
            mem_sel_q <= ~mem_sel_q;
            state_q   <= SEQ_NEXT;
          end else if ((limit_q != '0) && (timer_q == limit_q - TIMEOUT_W'(1))) begin
            error_q     <= 1'b1;
            err_layer_q <= cur_q;
            state_q     <= SEQ_ERR;
          end else begin
            timer_q <= timer_q + TIMEOUT_W'(1);
          end
        end
        SEQ_NEXT: begin
          if (abort) begin
            state_q <= SEQ_IDLE;
          end else if (find_found) begin
            cur_q   <= find_idx;
            state_q <= SEQ_LAUNCH;
          end else begin
            state_q <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          frame_q <= frame_q + FRAME_W'(1);
          state_q <= SEQ_IDLE;
        end
        SEQ_ERR: begin
          if (abort) state_q <= SEQ_IDLE;
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  // Start pulse is masked by abort so an aborted LAUNCH never kicks an engine.
  always_comb begin
    layer_start = '0;
    if ((state_q == SEQ_LAUNCH) && !abort) layer_start = NUM_LAYERS'(1) << cur_q;
  end

  assign busy      = (state_q == SEQ_LAUNCH) || (state_q == SEQ_WAIT) ||
                     (state_q == SEQ_NEXT)   || (state_q == SEQ_DONE);
  assign net_done  = (state_q == SEQ_DONE);
  assign mem_sel   = mem_sel_q;
  assign cur_layer = cur_q;
  assign error     = error_q;
  assign err_layer = err_layer_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a frame-level timeline model predicts
// start/done pulses, a negedge monitor checks them as the DUT produces them.
module tb_layer_sequencer;

  localparam int NL = 4;
  localparam int IW = 2;
  localparam int TW = 20;
  localparam int FW = 2;
  localparam int NEVER = 1000000;

  logic          clk = 1'b0;
  logic          srstn = 1'b0;
  logic          net_start = 1'b0;
  logic          abort = 1'b0;
  logic [NL-1:0] layer_en_mask = '0;
  logic [TW-1:0] timeout_limit = '0;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_done;
  logic [NL-1:0] eng_done = '0;
  logic [NL-1:0] extra_done = '0;
  logic          mem_sel;
  logic [IW-1:0] cur_layer;
  logic          busy;
  logic          net_done;
  logic          error;
  logic [IW-1:0] err_layer;
  logic [FW-1:0] frame_cnt;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int fc_model = 0;
  int eng_delay[NL];
  int eng_cnt[NL];

  typedef struct {
    int cyc;
    int kind;   // 0 = layer start, 1 = net_done
    int idx;
    int sel;
    int fc;
  } ev_t;
  ev_t exp_q[$];

  assign layer_done = eng_done | extra_done;

  layer_sequencer #(
    .NUM_LAYERS (NL),
    .IDX_W      (IW),
    .TIMEOUT_W  (TW),
    .FRAME_W    (FW)
  ) dut (
    .clk           (clk),
    .srstn         (srstn),
    .net_start     (net_start),
    .abort         (abort),
    .layer_en_mask (layer_en_mask),
    .timeout_limit (timeout_limit),
    .layer_start   (layer_start),
    .layer_done    (layer_done),
    .mem_sel       (mem_sel),
    .cur_layer     (cur_layer),
    .busy          (busy),
    .net_done      (net_done),
    .error         (error),
    .err_layer     (err_layer),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engines answer a start pulse with a done pulse eng_delay cycles later (0 = never).
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      eng_done[i] = 1'b0;
      if (!srstn) begin
        eng_cnt[i] = 0;
      end else begin
        if (eng_cnt[i] > 0) begin
          eng_cnt[i] = eng_cnt[i] - 1;
          if (eng_cnt[i] == 0) eng_done[i] = 1'b1;
        end
        if (layer_start[i] && eng_delay[i] > 0) eng_cnt[i] = eng_delay[i];
      end
    end
  end

  ev_t          mon_e;
  logic [NL:0]  mon_exp;
  always @(negedge clk) begin
    if (srstn && (layer_start != '0 || net_done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {net_done, layer_start}, 0);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_exp = '0;
        if (mon_e.kind == 1) mon_exp[NL] = 1'b1;
        else mon_exp[mon_e.idx] = 1'b1;
        check("event_cycle", cyc, mon_e.cyc);
        check("event_vector", {net_done, layer_start}, mon_exp);
        check("event_mem_sel", mem_sel, mon_e.sel);
        if (mon_e.kind == 0) check("event_cur_layer", cur_layer, mon_e.idx);
        else check("event_frame_cnt", frame_cnt, mon_e.fc);
      end
    end
  end

  task automatic push_ev(input int c, input int k, input int i, input int s, input int f);
    ev_t e;
    e.cyc = c; e.kind = k; e.idx = i; e.sel = s; e.fc = f;
    exp_q.push_back(e);
  endtask

  // Frame timeline: start at c0+1, done d cycles after start, next start two cycles
  // after done, net_done two cycles after the last done; ERR L+1 cycles after start.
  task automatic predict(input logic [NL-1:0] m, input int lim, input int c0, input int ab,
                         output int idle_c, output int outc, output int el,
                         output int sel_o, output int ab_used);
    int ns;
    int sel;
    int resp;
    int wend;
    ns = c0 + 1; sel = 0; outc = 0; el = 0; ab_used = 0; idle_c = 0; sel_o = 0;
    if (m == '0) begin
      push_ev(c0 + 1, 1, 0, 0, fc_model);
      fc_model = (fc_model + 1) % (1 << FW);
      idle_c = c0 + 2;
      return;
    end
    for (int i = 0; i < NL; i++) begin
      if (m[i]) begin
        if (ab == ns) begin
          ab_used = 1; outc = 2; idle_c = ns + 1; sel_o = sel;
          return;
        end
        push_ev(ns, 0, i, sel, 0);
        resp = (eng_delay[i] > 0) ? ns + eng_delay[i] : NEVER;
        wend = resp;
        if (lim > 0 && ns + lim < wend) wend = ns + lim;
        if (ab > ns && ab <= wend) begin
          ab_used = 1; outc = 2; idle_c = ab + 1; sel_o = sel;
          return;
        end
        if (resp <= wend) begin
          sel = sel ^ 1;
          if (ab == resp + 1) begin
            ab_used = 1; outc = 2; idle_c = resp + 2; sel_o = sel;
            return;
          end
          ns = resp + 2;
        end else begin
          outc = 1; el = i; idle_c = ns + lim + 1; sel_o = sel;
          return;
        end
      end
    end
    push_ev(ns, 1, 0, sel, fc_model);
    fc_model = (fc_model + 1) % (1 << FW);
    idle_c = ns + 1;
    sel_o = sel;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input logic [NL-1:0] m, input int lim, input int ab_off,
                           input bit spurious);
    int c0, ab, idle_c, outc, el, sel_o, ab_used;
    @(posedge clk); #1;
    c0 = cyc;
    ab = (ab_off >= 0) ? c0 + ab_off : -1;
    layer_en_mask = m;
    timeout_limit = TW'(lim);
    net_start = 1'b1;
    predict(m, lim, c0, ab, idle_c, outc, el, sel_o, ab_used);
    if (ab_used == 0) ab = -1;
    while (cyc < idle_c) begin
      @(posedge clk); #1;
      net_start  = (cyc <= c0 + 1);
      abort      = (cyc == ab);
      extra_done = (spurious && cyc == c0 + 3) ? 4'b0100 : 4'b0000;
      if (cyc == c0 + 1) check("error_cleared_on_start", error, 0);
      if (cyc == idle_c - 1) check("busy_last_cycle", busy, 1);
    end
    check("busy_after_frame", busy, 0);
    check("error_after_frame", error, (outc == 1) ? 1 : 0);
    if (outc == 1) check("err_layer", err_layer, el);
    check("mem_sel_after_frame", mem_sel, sel_o);
    check("frame_cnt_after_frame", frame_cnt, fc_model);
    check("scoreboard_drained", exp_q.size(), 0);
    if (outc == 1) begin
      net_start = 1'b1;
      idle_cycles(3);
      net_start = 1'b0;
      check("err_ignores_start_busy", busy, 0);
      check("err_ignores_start_error", error, 1);
      abort = 1'b1;
      idle_cycles(1);
      abort = 1'b0;
      idle_cycles(1);
      check("error_sticky_after_abort", error, 1);
      check("err_layer_held", err_layer, el);
    end
    if (outc != 0) idle_cycles(16);
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    eng_delay[0] = d0; eng_delay[1] = d1; eng_delay[2] = d2; eng_delay[3] = d3;
  endtask

  initial begin
    int lim, ab_off;
    logic [NL-1:0] m;
    int c0, idle_c, outc, el, sel_o, ab_used;
    set_delays(10, 10, 10, 10);
    for (int i = 0; i < NL; i++) eng_cnt[i] = 0;
    idle_cycles(3);
    check("reset_outputs",
          {layer_start, mem_sel, cur_layer, busy, net_done, error, err_layer, frame_cnt}, 0);
    srstn = 1'b1;
    idle_cycles(2);

    set_delays(10, 10, 10, 10);
    run_frame(4'b1111, 0, -1, 1'b0);
    run_frame(4'b1010, 0, -1, 1'b0);
    check("mask1010_cur_layer", cur_layer, 3);
    run_frame(4'b0000, 0, -1, 1'b0);
    set_delays(3, 3, 0, 3);
    run_frame(4'b1111, 5, -1, 1'b0);
    set_delays(4, 10, 4, 4);
    run_frame(4'b0110, 0, 6, 1'b1);
    set_delays(2, 2, 2, 2);
    run_frame(4'b0101, 0, -1, 1'b0);

    // Asynchronous reset in the middle of layer 0's WAIT
    set_delays(10, 10, 10, 10);
    @(posedge clk); #1;
    c0 = cyc;
    layer_en_mask = 4'b1111;
    timeout_limit = '0;
    net_start = 1'b1;
    predict(4'b1111, 0, c0, -1, idle_c, outc, el, sel_o, ab_used);
    idle_cycles(1);
    net_start = 1'b0;
    idle_cycles(3);
    check("pre_reset_busy", busy, 1);
    srstn = 1'b0;
    #1;
    check("async_reset_outputs",
          {layer_start, mem_sel, cur_layer, busy, net_done, error, err_layer, frame_cnt}, 0);
    exp_q.delete();
    fc_model = 0;
    idle_cycles(2);
    srstn = 1'b1;
    idle_cycles(2);

    // frame_cnt wraps after 2^FW completed frames
    for (int k = 0; k < (1 << FW); k++) run_frame(4'b0000, 0, -1, 1'b0);
    check("frame_cnt_wrap", frame_cnt, 0);

    for (int f = 0; f < 40; f++) begin
      m = NL'($urandom_range(0, 15));
      lim = ($urandom % 2 == 0) ? 0 : int'($urandom_range(2, 12));
      for (int i = 0; i < NL; i++) begin
        eng_delay[i] = int'($urandom_range(1, 12));
        if (lim != 0 && $urandom % 4 == 0) eng_delay[i] = 0;
      end
      ab_off = ($urandom % 5 == 0) ? int'($urandom_range(1, 30)) : -1;
      run_frame(m, lim, ab_off, 1'b0);
    end

    idle_cycles(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
